key_led_pattern: RTL

//   Parametrised key-controlled LED pattern generator. Two debounced push-keys select one of four

---
 rtl/key_led_pkg.sv | 15 +
 rtl/key_debounce.sv | 31 +++
 rtl/key_led_pattern.sv | 66 ++++++
 3 files changed

// File: rtl/key_led_pkg.sv
// key_led_pkg: shared mode encoding, fast-rate divider and mode sequencing helper
package key_led_pkg;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ALT   = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;
  localparam int FAST_DIV = 4;
  function automatic mode_t next_mode(mode_t m);
    logic [1:0] v;
    v = m + 2'd1;
    return mode_t'(v);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise a raw active-low key and emit one pulse per accepted press
module key_debounce #(
  parameter int DEB_MAX = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic press
);
  localparam int DW = $clog2(DEB_MAX);
  logic [1:0]    sync;
  logic          stable;
  logic [DW-1:0] cnt;
  logic          hit;
  // a level is accepted once it has differed from the stable value for DEB_MAX cycles
  assign hit = (sync[1] != stable) && (cnt == DW'(DEB_MAX - 1));
  // synchroniser, stability counter, and a press pulse registered alongside the 1->0 acceptance
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync   <= {sync[0], key_in};
      stable <= hit ? sync[1] : stable;
      cnt    <= (sync[1] == stable || hit) ? '0 : cnt + 1'b1;
      press  <= hit & stable;
    end
  end
endmodule

// File: rtl/key_led_pattern.sv
// key_led_pattern: two debounced keys pick an LED display mode and a normal/fast step rate
module key_led_pattern
  import key_led_pkg::*;
#(
  parameter int NUM_LED  = 4,
  parameter int TICK_MAX = 25_000_000,
  parameter int DEB_MAX  = 1_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         key,
  output logic [NUM_LED-1:0] led,
  output logic [1:0]         mode,
  output logic               fast
);
  localparam int CW = $clog2(TICK_MAX);
  localparam int IW = $clog2(NUM_LED);
  localparam logic [CW-1:0] P_NORM = CW'(TICK_MAX - 1);
  localparam logic [CW-1:0] P_FAST = CW'(TICK_MAX / FAST_DIV - 1);
  logic               press_m, press_f, adv, tick;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               phase, phase_nxt, fast_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  mode_t              state, state_nxt;
  logic [NUM_LED-1:0] even, led_nxt;
  key_debounce #(.DEB_MAX(DEB_MAX)) u_deb_mode (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key[0]), .press(press_m)
  );
  key_debounce #(.DEB_MAX(DEB_MAX)) u_deb_fast (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key[1]), .press(press_f)
  );
  assign mode = state;
  // next-state: a mode/rate change restarts the step sequence; led is decoded from next state
  always_comb begin
    even = '0;
    for (int i = 0; i < NUM_LED; i += 2) even[i] = 1'b1;
    tick      = cnt == (fast ? P_FAST : P_NORM);
    adv       = press_m | press_f;
    state_nxt = press_m ? next_mode(state) : state;
    fast_nxt  = fast ^ press_f;
    cnt_nxt   = (adv || tick) ? '0 : cnt + 1'b1;
    phase_nxt = adv ? 1'b0 : phase ^ tick;
    idx_nxt   = adv ? '0 : !tick ? idx : (idx == IW'(NUM_LED - 1)) ? '0 : idx + 1'b1;
    led_nxt   = state_nxt == MODE_ALT   ? (phase_nxt ? ~even : even) :
                state_nxt == MODE_BLINK ? {NUM_LED{~phase_nxt}} :
                state_nxt == MODE_CHASE ? NUM_LED'(1) << idx_nxt : '0;
  end
  // state register for mode, rate, step counter, pattern position and LED drive
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= MODE_OFF;
      fast  <= 1'b0;
      cnt   <= '0;
      phase <= 1'b0;
      idx   <= '0;
      led   <= '0;
    end else begin
      state <= state_nxt;
      fast  <= fast_nxt;
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
      idx   <= idx_nxt;
      led   <= led_nxt;
    end
  end
endmodule
